// File: rtl/multicycle_control_if.sv
// Control-unit boundary: instruction fields and status flags in, datapath controls out.
// master = control unit, slave = datapath.
interface multicycle_control_if;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5;
   logic       zero;
   logic       mem_ready;
   logic       pc_write;
   logic       ir_write;
   logic       reg_write;
   logic       mem_read;
   logic       mem_write;
   logic       mem_to_reg;
   logic       pc_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic       instr_done;
   logic       error;
   logic [2:0] state;

   modport master (
      input  opcode, funct3, funct7_5, zero, mem_ready,
      output pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
             pc_src, alu_src_a, alu_src_b, alu_op, instr_done, error, state
   );

   modport slave (
      output opcode, funct3, funct7_5, zero, mem_ready,
      input  pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
             pc_src, alu_src_a, alu_src_b, alu_op, instr_done, error, state
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32 subset control FSM (lh/sh/andi/sub/or/srl/beq) with a memory
// wait timeout that traps; outputs are combinational from state and inputs.
module multicycle_control #(
   parameter int MEM_WAIT_MAX = 15
) (
   input logic                 clk,
   input logic                 rst_n,
   multicycle_control_if.master cif
);

   localparam int WCW = ($clog2(MEM_WAIT_MAX + 1) > 4) ? $clog2(MEM_WAIT_MAX + 1) : 4;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_SRL = 3'b100
   } alu_op_t;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       instr_done;
      logic       error;
   } ctrl_t;

   state_t         state_q, state_nxt;
   logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
   ctrl_t          ctl;

   logic is_lh, is_sh, is_andi, is_sub, is_or, is_srl, is_beq, is_rtype, legal, timeout;

   always_comb begin
      is_lh    = (cif.opcode == 7'b0000011) && (cif.funct3 == 3'b001);
      is_sh    = (cif.opcode == 7'b0100011) && (cif.funct3 == 3'b001);
      is_andi  = (cif.opcode == 7'b0010011) && (cif.funct3 == 3'b111);
      is_sub   = (cif.opcode == 7'b0110011) && (cif.funct3 == 3'b000) && cif.funct7_5;
      is_or    = (cif.opcode == 7'b0110011) && (cif.funct3 == 3'b110);
      is_srl   = (cif.opcode == 7'b0110011) && (cif.funct3 == 3'b101) && !cif.funct7_5;
      is_beq   = (cif.opcode == 7'b1100011) && (cif.funct3 == 3'b000);
      is_rtype = is_sub || is_or || is_srl;
      legal    = is_lh || is_sh || is_andi || is_rtype || is_beq;
   end

   // mem_ready wins over the timeout in the boundary cycle
   assign timeout = (wait_cnt == WCW'(MEM_WAIT_MAX)) && !cif.mem_ready;

   always_comb begin
      ctl       = '0;
      state_nxt = state_q;
      case (state_q)
         S_FETCH: begin
            ctl.mem_read  = 1'b1;
            ctl.alu_src_b = 2'b01;
            if (cif.mem_ready) begin
               ctl.ir_write = 1'b1;
               ctl.pc_write = 1'b1;
               state_nxt    = S_DECODE;
            end else if (timeout) begin
               state_nxt = S_TRAP;
            end
         end
         S_DECODE: begin
            ctl.alu_src_b = 2'b10;
            state_nxt     = legal ? S_EXEC : S_TRAP;
         end
         S_EXEC: begin
            ctl.alu_src_a = 1'b1;
            if (is_rtype) begin
               ctl.alu_op = is_sub ? OP_SUB : (is_or ? OP_OR : OP_SRL);
               state_nxt  = S_WB;
            end else if (is_andi) begin
               ctl.alu_src_b = 2'b10;
               ctl.alu_op    = OP_AND;
               state_nxt     = S_WB;
            end else if (is_lh || is_sh) begin
               ctl.alu_src_b = 2'b10;
               state_nxt     = S_MEM;
            end else if (is_beq) begin
               ctl.alu_op     = OP_SUB;
               ctl.pc_src     = 1'b1;
               ctl.pc_write   = cif.zero;
               ctl.instr_done = 1'b1;
               state_nxt      = S_FETCH;
            end else begin
               // IR changed under us after decode; nothing sane to retire
               ctl.alu_src_a = 1'b0;
               state_nxt     = S_TRAP;
            end
         end
         S_MEM: begin
            if (is_lh || is_sh) begin
               ctl.mem_read  = is_lh;
               ctl.mem_write = is_sh;
               if (cif.mem_ready) begin
                  ctl.instr_done = is_sh;
                  state_nxt      = is_lh ? S_WB : S_FETCH;
               end else if (timeout) begin
                  state_nxt = S_TRAP;
               end
            end else begin
               state_nxt = S_TRAP;
            end
         end
         S_WB: begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = is_lh;
            ctl.instr_done = 1'b1;
            state_nxt      = S_FETCH;
         end
         S_TRAP: begin
            ctl.error = 1'b1;
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      wait_cnt_nxt = wait_cnt;
      if (state_nxt != state_q)
         wait_cnt_nxt = '0;
      else if ((state_q == S_FETCH || state_q == S_MEM) && !cif.mem_ready)
         wait_cnt_nxt = wait_cnt + WCW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         wait_cnt <= '0;
      end else begin
         state_q  <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // FETCH drives mem_read combinationally, so everything is gated while in reset
   assign cif.pc_write   = rst_n & ctl.pc_write;
   assign cif.ir_write   = rst_n & ctl.ir_write;
   assign cif.reg_write  = rst_n & ctl.reg_write;
   assign cif.mem_read   = rst_n & ctl.mem_read;
   assign cif.mem_write  = rst_n & ctl.mem_write;
   assign cif.mem_to_reg = rst_n & ctl.mem_to_reg;
   assign cif.pc_src     = rst_n & ctl.pc_src;
   assign cif.alu_src_a  = rst_n & ctl.alu_src_a;
   assign cif.alu_src_b  = rst_n ? ctl.alu_src_b : 2'b00;
   assign cif.alu_op     = rst_n ? ctl.alu_op : 3'b000;
   assign cif.instr_done = rst_n & ctl.instr_done;
   assign cif.error      = rst_n & ctl.error;
   assign cif.state      = rst_n ? state_q : S_FETCH;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: expected per-cycle output traces are
// built from each instruction's class and its memory wait-state counts.
module tb_multicycle_control;

   localparam int C_ILL = 0, C_LH = 1, C_SH = 2, C_ANDI = 3, C_SUB = 4, C_OR = 5,
                  C_SRL = 6, C_BEQ = 7;

   typedef struct packed {
      logic [2:0] st;
      logic       pcw, irw, rw, mr, mw, m2r, pcs, asa;
      logic [1:0] asb;
      logic [2:0] aop;
      logic       done, err;
   } ov_t;

   logic clk, rst_n;
   int   checks = 0;
   int   errors = 0;

   multicycle_control_if cif ();

   multicycle_control #(.MEM_WAIT_MAX(15)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .cif  (cif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic ov_t obs();
      ov_t o;
      o.st = cif.state;       o.pcw = cif.pc_write;  o.irw = cif.ir_write;
      o.rw = cif.reg_write;   o.mr = cif.mem_read;   o.mw = cif.mem_write;
      o.m2r = cif.mem_to_reg; o.pcs = cif.pc_src;    o.asa = cif.alu_src_a;
      o.asb = cif.alu_src_b;  o.aop = cif.alu_op;    o.done = cif.instr_done;
      o.err = cif.error;
      return o;
   endfunction

   function automatic int classify(logic [31:0] w);
      logic [6:0] op;
      logic [2:0] f3;
      op = w[6:0];
      f3 = w[14:12];
      if (op == 7'b0000011 && f3 == 3'b001) return C_LH;
      if (op == 7'b0100011 && f3 == 3'b001) return C_SH;
      if (op == 7'b0010011 && f3 == 3'b111) return C_ANDI;
      if (op == 7'b0110011 && f3 == 3'b000 && w[30]) return C_SUB;
      if (op == 7'b0110011 && f3 == 3'b110) return C_OR;
      if (op == 7'b0110011 && f3 == 3'b101 && !w[30]) return C_SRL;
      if (op == 7'b1100011 && f3 == 3'b000) return C_BEQ;
      return C_ILL;
   endfunction

   function automatic int lat_base(int cls);
      case (cls)
         C_LH:    return 5;
         C_BEQ:   return 3;
         default: return 4;
      endcase
   endfunction

   // Called at a falling edge; drives inputs, checks outputs, returns at next falling edge.
   task automatic step(input logic [31:0] w, input logic rdy, input logic z, input ov_t e,
                       input string tag);
      cif.opcode    = w[6:0];
      cif.funct3    = w[14:12];
      cif.funct7_5  = w[30];
      cif.mem_ready = rdy;
      cif.zero      = z;
      #1 chk(tag, 32'(obs()), 32'(e));
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      cif.mem_ready = 1'($urandom);
      #1 chk("reset", 32'(obs()), 32'd0);
      repeat (2) begin
         @(negedge clk);
         #1 chk("reset_hold", 32'(obs()), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic trap_hold(input int n);
      ov_t e;
      for (int i = 0; i < n; i++) begin
         e = '0; e.st = 3'd5; e.err = 1'b1;
         step($urandom, 1'($urandom), 1'($urandom), e, "trap");
      end
   endtask

   task automatic run_instr(input logic [31:0] w, input int fw, input int mwt, input logic z,
                            output bit trapped);
      int  cls;
      int  cyc;
      ov_t e;
      cls = classify(w);
      cyc = 0;
      trapped = 1'b0;
      for (int i = 0; i < fw && i < 16; i++) begin
         e = '0; e.mr = 1'b1; e.asb = 2'b01;
         step($urandom, 1'b0, 1'($urandom), e, "fetch_wait");
         cyc++;
      end
      if (fw >= 16) begin trapped = 1'b1; return; end
      e = '0; e.mr = 1'b1; e.asb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
      step($urandom, 1'b1, 1'($urandom), e, "fetch");
      cyc++;
      e = '0; e.st = 3'd1; e.asb = 2'b10;
      step(w, 1'($urandom), 1'($urandom), e, "decode");
      cyc++;
      if (cls == C_ILL) begin trapped = 1'b1; return; end
      e = '0; e.st = 3'd2; e.asa = 1'b1;
      case (cls)
         C_SUB:  e.aop = 3'b001;
         C_OR:   e.aop = 3'b011;
         C_SRL:  e.aop = 3'b100;
         C_ANDI: begin e.asb = 2'b10; e.aop = 3'b010; end
         C_BEQ:  begin e.aop = 3'b001; e.pcs = 1'b1; e.pcw = z; e.done = 1'b1; end
         default: e.asb = 2'b10;
      endcase
      step(w, 1'($urandom), (cls == C_BEQ) ? z : 1'($urandom), e, "exec");
      cyc++;
      if (cls == C_LH || cls == C_SH) begin
         for (int i = 0; i < mwt && i < 16; i++) begin
            e = '0; e.st = 3'd3; e.mr = (cls == C_LH); e.mw = (cls == C_SH);
            step(w, 1'b0, 1'($urandom), e, "mem_wait");
            cyc++;
         end
         if (mwt >= 16) begin trapped = 1'b1; return; end
         e = '0; e.st = 3'd3; e.mr = (cls == C_LH); e.mw = (cls == C_SH); e.done = (cls == C_SH);
         step(w, 1'b1, 1'($urandom), e, "mem");
         cyc++;
      end
      if (cls != C_BEQ && cls != C_SH) begin
         e = '0; e.st = 3'd4; e.rw = 1'b1; e.m2r = (cls == C_LH); e.done = 1'b1;
         step(w, 1'($urandom), 1'($urandom), e, "wb");
         cyc++;
      end
      chk("latency", 32'(cyc),
          32'(lat_base(cls) + fw + (((cls == C_LH) || (cls == C_SH)) ? mwt : 0)));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bit          t;
      ov_t         e;
      logic [31:0] w;
      logic [6:0]  ops[7];
      logic [2:0]  f3s[7];
      ops = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b1100011};
      f3s = '{3'b001, 3'b001, 3'b111, 3'b000, 3'b110, 3'b101, 3'b000};

      rst_n = 1'b0;
      cif.opcode = '0; cif.funct3 = '0; cif.funct7_5 = 1'b0; cif.zero = 1'b0; cif.mem_ready = 1'b0;
      @(negedge clk);
      do_reset();

      run_instr(32'h403100B3, 0, 0, 1'b0, t);            // sub x1,x2,x3
      run_instr(32'hFEC29503, 0, 2, 1'b0, t);            // lh x10,-20(x5)
      run_instr(32'hFE2088E3, 0, 0, 1'b1, t);            // beq taken
      run_instr(32'hFE2088E3, 1, 0, 1'b0, t);            // beq not taken
      run_instr(32'h00000023 | (32'd1 << 12), 0, 0, 1'b0, t);  // sh, no waits
      run_instr(32'h403100B3, 15, 0, 1'b0, t);           // ready on 16th cycle wins

      run_instr(32'h00000037, 0, 0, 1'b0, t);            // lui: illegal here
      trap_hold(20);
      do_reset();

      run_instr(32'h403100B3, 16, 0, 1'b0, t);           // fetch timeout
      trap_hold(3);
      do_reset();

      run_instr(32'hFEC29503, 0, 16, 1'b0, t);           // lh memory timeout
      trap_hold(3);
      do_reset();

      // reset asserted while sh is waiting in MEM
      w = 32'h00000023 | (32'd1 << 12);
      e = '0; e.mr = 1'b1; e.asb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
      step($urandom, 1'b1, 1'b0, e, "sh_fetch");
      e = '0; e.st = 3'd1; e.asb = 2'b10;
      step(w, 1'b0, 1'b0, e, "sh_decode");
      e = '0; e.st = 3'd2; e.asa = 1'b1; e.asb = 2'b10;
      step(w, 1'b0, 1'b0, e, "sh_exec");
      e = '0; e.st = 3'd3; e.mw = 1'b1;
      step(w, 1'b0, 1'b0, e, "sh_mem_wait");
      do_reset();
      run_instr(32'h403100B3, 0, 0, 1'b0, t);

      for (int k = 0; k < 150; k++) begin
         int idx;
         int fw, mwt;
         if ($urandom_range(0, 9) < 8) begin
            idx = $urandom_range(0, 6);
            w = $urandom;
            w[6:0] = ops[idx];
            w[14:12] = f3s[idx];
            if (idx == 3) w[30] = 1'b1;
            if (idx == 5) w[30] = 1'b0;
         end else begin
            w = $urandom;
         end
         fw  = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
         mwt = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
         run_instr(w, fw, mwt, 1'($urandom), t);
         if (t) begin
            trap_hold($urandom_range(1, 4));
            do_reset();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15: the largest wait count tolerated in FETCH or MEM before a timeout trap.
REQ-002 SHALL have port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port opcode  input  7  IR[6:0].
REQ-005 SHALL have port funct3  input  3  IR[14:12].
REQ-006 SHALL have port funct7_5  input  1  IR[30].
REQ-007 SHALL have port zero  input  1  ALU zero flag.
REQ-008 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-009 SHALL have outputs pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg, pc_src, alu_src_a, instr_done, error, each 1 bit.
- pc_src: 0 = ALU result, 1 = ALUOut register.
- alu_src_a: 0 = PC, 1 = rs1.
REQ-010 SHALL have output alu_src_b  2 bits: 00 = rs2, 01 = constant 4, 10 = immediate-generator output.
REQ-011 SHALL have output alu_op  3 bits: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SRL.
REQ-012 SHALL have output state  3 bits, debug encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

Function
REQ-013 SHALL decode exactly the following as legal; every other opcode/funct combination SHALL be illegal:
- lh: 0000011, funct3 001
- sh: 0100011, funct3 001
- andi: 0010011, funct3 111
- sub: 0110011, funct3 000, f7_5=1
- or: 0110011, funct3 110
- srl: 0110011, funct3 101, f7_5=0
- beq: 1100011, funct3 000
REQ-014 SHALL behave in FETCH as follows:
- Drive mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=0.
- On mem_ready=1, drive ir_write=1 and pc_write=1 in the same cycle, then go to DECODE.
REQ-015 SHALL behave in DECODE as follows:
- Drive alu_src_a=0, alu_src_b=10, alu_op=ADD (branch target into ALUOut).
- Go to TRAP if the instruction is illegal, else go to EXEC.
REQ-016 SHALL behave in EXEC as follows:
- R-type: alu_src_a=1, alu_src_b=00, alu_op per instruction, then WB.
- andi: alu_src_a=1, alu_src_b=10, alu_op=AND, then WB.
- lh/sh: alu_src_a=1, alu_src_b=10, alu_op=ADD, then MEM.
- beq: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=1, pc_write=zero, instr_done=1, then FETCH.
REQ-017 SHALL behave in MEM as follows:
- lh: mem_read=1 until mem_ready, then WB.
- sh: mem_write=1 until mem_ready; in the mem_ready cycle instr_done=1, then FETCH.
REQ-018 SHALL behave in WB as follows: reg_write=1, mem_to_reg=1 only for lh, instr_done=1, then FETCH.
REQ-019 SHALL make TRAP absorbing:
- error=1.
- Every other output 0.
- Exit only by reset.
REQ-020 SHALL generate control outputs combinationally from state, opcode/funct, zero and mem_ready; only state and wait_cnt are registered.
REQ-021 SHALL run a wait counter wait_cnt, 4 bits minimum, sized to hold MEM_WAIT_MAX:
- Clears on entry to FETCH or MEM.
- Increments on each FETCH/MEM cycle with mem_ready=0.
REQ-022 SHALL go to TRAP when wait_cnt==MEM_WAIT_MAX and mem_ready=0; with MEM_WAIT_MAX=15, the 16th consecutive low cycle traps.
REQ-023 SHALL give mem_ready=1 precedence over the timeout in that boundary cycle.
REQ-024 SHALL drive each instr_done pulse for exactly one cycle per retired instruction; a trapped instruction SHALL never assert instr_done.
REQ-025 SHALL set instruction latency with zero memory wait states as follows:
- sub/or/srl/andi: 4 cycles.
- lh: 5 cycles.
- sh: 4 cycles.
- beq: 3 cycles.

Reset
REQ-026 SHALL, while rst_n=0 in any state including mid-MEM or TRAP, force state=FETCH, wait_cnt=0, error=0, and every other output to 0, with all outputs gated by rst_n.
REQ-027 SHALL assert the first mem_read in the first cycle after rst_n rises.

Verification
REQ-028 SHALL cover sub x1,x2,x3 (0x403100B3) with mem_ready=1 -> states 0,1,2,4; alu_op=001 in EXEC; reg_write=1 and instr_done=1 in WB; 4 cycles.
REQ-029 SHALL cover lh x10,-20(x5) (0xFEC29503) with mem_ready low 2 cycles in MEM -> mem_read held 3 MEM cycles; WB has mem_to_reg=1 and reg_write=1; 7 cycles total.
REQ-030 SHALL cover beq (0xFE2088E3) -> zero=1 gives pc_write=1 with pc_src=1 in EXEC; zero=0 gives pc_write=0; both then FETCH.
REQ-031 SHALL cover an illegal opcode 0110111 -> TRAP after DECODE; error=1 held 20 cycles; no instr_done pulse.
REQ-032 SHALL cover the FETCH timeout -> mem_ready=0 for 16 cycles gives TRAP; a rerun with mem_ready=1 on the 16th cycle gives DECODE instead.
REQ-033 SHALL cover rst_n pulled low mid-MEM of sh -> same-cycle mem_write=0 and state=0; after release, FETCH resumes with mem_read=1.
